mario_inputs: RTL
=================

# mario_inputs

Input conditioning stage that sits directly upstream of the Mario Bros core's switch inputs. It converts the raw 16-bit MiSTer joystick words and the DIP-switch download stream into the active-low `I_SW1`, `I_SW2` and `I_DIPSW` buses that `mario_top` consumes. Along the way it arbitrates left/right per player, debounces the coin input and stretches it into a fixed-width pulse, and latches DIP byte 0. The whole block runs in the 24 MHz system domain.

## Interface
Parameters:
- `DEBOUNCE_CYC`, default 24000: cycles the merged coin input must be stable before it is accepted (1 ms at 24 MHz).
- `COIN_PULSE_CYC`, default 2400000: width of the coin pulse, in cycles (100 ms).

Ports:
- `I_CLK_24M` in 1: system clock, single clock domain.
- `I_RESETn` in 1: reset, synchronous, active-low.
- `I_JOY0` in 16: player 1 joystick. Bit 0 R, bit 1 L, bit 4 jump, bit 5 start1, bit 6 start2, bit 7 coin, bit 8 test. Active-high.
- `I_JOY1` in 16: player 2 joystick, same bit map.
- `I_IOCTL_WR` in 1: download write strobe.
- `I_IOCTL_INDEX` in 8: download index.
- `I_IOCTL_ADDR` in 25: download byte address.
- `I_IOCTL_DOUT` in 8: download data.
- `O_SW1` out 8: {~test, ~start2, ~start1, ~jump0, 1, 1, ~left0, ~right0}.
- `O_SW2` out 8: {1, 1, ~coin, ~jump1, 1, 1, ~left1, ~right1}.
- `O_DIPSW` out 8: latched DIP byte 0.
- `O_DIP_VALID` out 1: high once DIP byte 0 has been written.

## Operation
- **Input capture.** Both joystick words are registered once (stage 1).
- **Start and test merge.** start1, start2 and test are each the OR of that bit across `I_JOY0` and `I_JOY1`.
- **Left/right arbiter (one per player).**
  - Rising-edge detect on the registered {L,R} pair.
  - `last` register: an R rise sets it to 01, an L rise sets it to 10. If both rise in the same cycle, L wins (10).
  - Output = `last` when L and R are both high, otherwise the raw registered pair.
  - `last` resets to 00, so both held with no edge history gives no direction.
- **Coin debouncer.**
  - Merged coin = `JOY0[7] | JOY1[7]`.
  - Counter restarts on any change of the merged coin. The stable level is updated only after `DEBOUNCE_CYC` consecutive equal samples.
- **Coin pulser.**
  - A rising edge of the stable level loads the pulse counter with `COIN_PULSE_CYC`. coin=1 while the counter is nonzero.
  - Edges while the counter is nonzero are ignored; there is no retrigger.
  - Holding coin longer than the pulse still ends the pulse, so each press gives exactly one pulse.
- **DIP latch.**
  - Latch condition: `I_IOCTL_WR && I_IOCTL_INDEX==254 && I_IOCTL_ADDR[24:0]==0`. On that condition `O_DIPSW <= I_IOCTL_DOUT` and `O_DIP_VALID <= 1`.
  - Writes to addresses 1..7, or to any other index, are ignored.
  - The DIP latch and valid flag are power-up initialised to 0 and are not affected by `I_RESETn`, because the core reset is pulsed after the DIP load.
- **Reset values.**
  - `O_SW1` = 8'hFF, `O_SW2` = 8'hFF.
  - Arbiter `last` = 00; debounce counter and stable level = 0; pulse counter = 0.
  - If reset is asserted mid-pulse, the pulse terminates in the same cycle that reset is sampled.

## Timing
- Joystick bit to `O_SW1`/`O_SW2`: 2 cycles (capture register, output register). This includes arbitrated directions.
- Coin: a clean press reaches `O_SW2[5]`=0 in `DEBOUNCE_CYC`+3 cycles and stays low for exactly `COIN_PULSE_CYC` cycles.
- DIP: `O_DIPSW` and `O_DIP_VALID` update on the clock edge following the qualifying write.
- Counter widths:
  - `$clog2(DEBOUNCE_CYC+1)` and `$clog2(COIN_PULSE_CYC+1)`.
  - Counters saturate and never wrap.
- `DEBOUNCE_CYC`=0 bypasses the debouncer (stable level = registered input).

## Structure
- Package `mario_inputs_pkg`:
  - Joystick bit-index constants `JOY_R`, `JOY_L`, `JOY_JUMP`, `JOY_START1`, `JOY_START2`, `JOY_COIN`, `JOY_TEST`.
  - `DIP_INDEX` = 8'd254.
- Sub-module `mario_lr_arbiter` (inputs: clk, reset, {L,R}; output: {L,R}), instantiated once per player.
- The debouncer, pulser, DIP latch and bus assembly stay in the top of the block.

## Test plan
- **Reset defaults.** Reset held, all inputs 0 -> `O_SW1`=8'hFF and `O_SW2`=8'hFF; after release, still FF.
- **Left/right arbitration.**
  - JOY0 R rises, then L rises 10 cycles later while R is held -> `O_SW1[1:0]`=2'b01 (L active) two cycles after the L rise.
  - Both released -> 2'b11.
  - L and R rise in the same cycle -> L wins.
- **Coin glitch rejection.** With `DEBOUNCE_CYC`=8 and `COIN_PULSE_CYC`=20, a 5-cycle coin glitch -> no pulse.
- **Coin pulse.** Same parameters, coin held 100 cycles -> `O_SW2[5]` low for exactly 20 cycles, starting 11 cycles after assertion. A second press during the pulse gives no extension.
- **DIP latch.**
  - Write index 254, addr 0, data 8'hA5 -> `O_DIPSW`=8'hA5 and `O_DIP_VALID`=1 next cycle.
  - Write addr 1 with data 8'h00 -> unchanged.
  - Pulse `I_RESETn` -> still 8'hA5.
- **Start/test merge and reset mid-pulse.**
  - JOY1 start1 -> `O_SW1[5]`=0.
  - Reset asserted mid-pulse -> `O_SW2`=8'hFF on the next edge.

Source files
------------

// File: rtl/mario_inputs_pkg.sv
// Shared constants and types for the Mario Bros input conditioning block.
package mario_inputs_pkg;

    localparam int JOY_R      = 0;
    localparam int JOY_L      = 1;
    localparam int JOY_JUMP   = 4;
    localparam int JOY_START1 = 5;
    localparam int JOY_START2 = 6;
    localparam int JOY_COIN   = 7;
    localparam int JOY_TEST   = 8;

    localparam logic [7:0] DIP_INDEX = 8'd254;

    typedef struct packed {
        logic l;
        logic r;
    } lr_t;

    // A zero-length count still needs a one-bit register to stay legal.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mario_lr_arbiter.sv
// Per-player left/right arbiter: when both directions are held, the most recent press wins.
module mario_lr_arbiter
    import mario_inputs_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  lr_t  i_lr,
    output lr_t  o_lr
);

    lr_t  r_prev;
    lr_t  r_last;
    logic w_rise_l;
    logic w_rise_r;
    lr_t  w_last_nxt;

    assign w_rise_l = i_lr.l & ~r_prev.l;
    assign w_rise_r = i_lr.r & ~r_prev.r;

    // The updated history is used in the same cycle so a fresh press adds no latency.
    always_comb begin
        w_last_nxt = r_last;
        if (w_rise_l)
            w_last_nxt = '{l: 1'b1, r: 1'b0};
        else if (w_rise_r)
            w_last_nxt = '{l: 1'b0, r: 1'b1};
    end

    assign o_lr = (i_lr.l && i_lr.r) ? w_last_nxt : i_lr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev <= '0;
            r_last <= '0;
        end else begin
            r_prev <= i_lr;
            r_last <= w_last_nxt;
        end
    end

endmodule

// File: rtl/mario_inputs.sv
// Converts MiSTer joystick words and the DIP download stream into the active-low
// switch buses of the Mario Bros core.
module mario_inputs
    import mario_inputs_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = 24000,
    parameter int COIN_PULSE_CYC = 2400000
) (
    input  logic        I_CLK_24M,
    input  logic        I_RESETn,
    input  logic [15:0] I_JOY0,
    input  logic [15:0] I_JOY1,
    input  logic        I_IOCTL_WR,
    input  logic [7:0]  I_IOCTL_INDEX,
    input  logic [24:0] I_IOCTL_ADDR,
    input  logic [7:0]  I_IOCTL_DOUT,
    output logic [7:0]  O_SW1,
    output logic [7:0]  O_SW2,
    output logic [7:0]  O_DIPSW,
    output logic        O_DIP_VALID
);

    localparam int DB_W = cnt_width(DEBOUNCE_CYC);
    localparam int PL_W = cnt_width(COIN_PULSE_CYC);

    logic [15:0]     r_joy0;
    logic [15:0]     r_joy1;
    logic [7:0]      r_sw1;
    logic [7:0]      r_sw2;
    logic            r_stable_d;
    logic [PL_W-1:0] r_pulse_cnt;
    logic [7:0]      r_dipsw      = '0;
    logic            r_dip_valid  = 1'b0;

    logic w_start1;
    logic w_start2;
    logic w_test;
    logic w_coin_raw;
    logic w_coin_stable;
    logic w_coin_pulse;
    lr_t  w_lr0;
    lr_t  w_lr1;
    logic w_unused;

    assign w_unused = ^{r_joy0[15:9], r_joy0[3:2], r_joy1[15:9], r_joy1[3:2]};

    // Stage 1: joystick capture.
    always_ff @(posedge I_CLK_24M) begin
        r_joy0 <= I_JOY0;
        r_joy1 <= I_JOY1;
    end

    assign w_start1   = r_joy0[JOY_START1] | r_joy1[JOY_START1];
    assign w_start2   = r_joy0[JOY_START2] | r_joy1[JOY_START2];
    assign w_test     = r_joy0[JOY_TEST]   | r_joy1[JOY_TEST];
    assign w_coin_raw = r_joy0[JOY_COIN]   | r_joy1[JOY_COIN];

    mario_lr_arbiter u_arb0 (
        .i_clk   (I_CLK_24M),
        .i_rst_n (I_RESETn),
        .i_lr    ({r_joy0[JOY_L], r_joy0[JOY_R]}),
        .o_lr    (w_lr0)
    );

    mario_lr_arbiter u_arb1 (
        .i_clk   (I_CLK_24M),
        .i_rst_n (I_RESETn),
        .i_lr    ({r_joy1[JOY_L], r_joy1[JOY_R]}),
        .o_lr    (w_lr1)
    );

    // Coin debouncer: any sample equal to the accepted level restarts the run.
    generate
        if (DEBOUNCE_CYC == 0) begin : g_db_bypass
            assign w_coin_stable = w_coin_raw;
        end else begin : g_db
            logic [DB_W-1:0] r_db_cnt;
            logic            r_db_stable;

            always_ff @(posedge I_CLK_24M) begin
                if (!I_RESETn) begin
                    r_db_cnt    <= '0;
                    r_db_stable <= 1'b0;
                end else if (w_coin_raw == r_db_stable) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                    r_db_cnt    <= '0;
                    r_db_stable <= w_coin_raw;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end

            assign w_coin_stable = r_db_stable;
        end
    endgenerate

    // Coin pulser: one fixed-width pulse per accepted press, no retrigger.
    always_ff @(posedge I_CLK_24M) begin
        if (!I_RESETn) begin
            r_stable_d  <= 1'b0;
            r_pulse_cnt <= '0;
        end else begin
            r_stable_d <= w_coin_stable;
            if (w_coin_stable && !r_stable_d && r_pulse_cnt == '0)
                r_pulse_cnt <= PL_W'(COIN_PULSE_CYC);
            else if (r_pulse_cnt != '0)
                r_pulse_cnt <= r_pulse_cnt - 1'b1;
        end
    end

    assign w_coin_pulse = (r_pulse_cnt != '0);

    // Stage 2: active-low switch buses.
    always_ff @(posedge I_CLK_24M) begin
        if (!I_RESETn) begin
            r_sw1 <= 8'hFF;
            r_sw2 <= 8'hFF;
        end else begin
            r_sw1 <= {~w_test, ~w_start2, ~w_start1, ~r_joy0[JOY_JUMP],
                      2'b11, ~w_lr0.l, ~w_lr0.r};
            r_sw2 <= {2'b11, ~w_coin_pulse, ~r_joy1[JOY_JUMP],
                      2'b11, ~w_lr1.l, ~w_lr1.r};
        end
    end

    // The DIP byte survives core reset, which is pulsed after the download.
    always_ff @(posedge I_CLK_24M) begin
        if (I_IOCTL_WR && I_IOCTL_INDEX == DIP_INDEX && I_IOCTL_ADDR == 25'd0) begin
            r_dipsw     <= I_IOCTL_DOUT;
            r_dip_valid <= 1'b1;
        end
    end

    assign O_SW1       = r_sw1;
    assign O_SW2       = r_sw2;
    assign O_DIPSW     = r_dipsw;
    assign O_DIP_VALID = r_dip_valid;

endmodule
